// File: rtl/datapath_if.sv
// Bundle between the accumulator datapath and its controller/memory.
// The master side drives control strobes and read data; the slave side is the datapath.
interface datapath_if;
  logic        pcWrite, pcDataSel, memAddressSel, memRead, memWrite;
  logic        ACwrite, ACread, ACaddressSel;
  logic [1:0]  ACdataSel;
  logic [2:0]  ALUcommand;
  logic        IRwritePart1, IRwritePart2, ALUBinputSel, DIwrite;
  logic        resultRegEn, dataRegEn, wordRegEn, CEn, ZEn, NEn;
  logic [3:0]  upcode;
  logic        C, Z, N;
  logic [11:0] memAddr;
  logic [7:0]  memWData, memRData;
  logic        memRd, memWr;

  modport master (
    output pcWrite, pcDataSel, memAddressSel, memRead, memWrite,
           ACwrite, ACread, ACaddressSel, ACdataSel, ALUcommand,
           IRwritePart1, IRwritePart2, ALUBinputSel, DIwrite,
           resultRegEn, dataRegEn, wordRegEn, CEn, ZEn, NEn, memRData,
    input  upcode, C, Z, N, memAddr, memWData, memRd, memWr
  );

  modport slave (
    input  pcWrite, pcDataSel, memAddressSel, memRead, memWrite,
           ACwrite, ACread, ACaddressSel, ACdataSel, ALUcommand,
           IRwritePart1, IRwritePart2, ALUBinputSel, DIwrite,
           resultRegEn, dataRegEn, wordRegEn, CEn, ZEn, NEn, memRData,
    output upcode, C, Z, N, memAddr, memWData, memRd, memWr
  );
endinterface

// File: rtl/datapath.sv
// Accumulator-machine datapath: PC, split instruction register, four-entry AC file,
// ALU with operand/result staging registers and C/Z/N flags. Synchronous active-high reset.
module datapath (
  input  logic      clk,
  input  logic      rst,
  datapath_if.slave bus
);
  logic [11:0] pc_q, pc_d;
  logic [7:0]  ir1_q, ir1_d, ir2_q, ir2_d, di_q, di_d;
  logic [7:0]  dataReg_q, dataReg_d, wordReg_q, wordReg_d, resultReg_q, resultReg_d;
  logic [7:0]  ac_q [4];
  logic [7:0]  ac_d [4];
  logic        c_q, c_d, z_q, z_d, n_q, n_d;

  logic [11:0] addrField;
  logic [1:0]  dstIdx, srcIdx, acIdx;
  logic [7:0]  acOut, acWrData, aluB, aluResult;
  logic [8:0]  aluSum;
  logic        aluCarry;

  assign addrField = {ir1_q[3:0], ir2_q};
  assign dstIdx    = ir1_q[3:2];
  assign srcIdx    = ir1_q[1:0];
  assign acIdx     = bus.ACaddressSel ? srcIdx : dstIdx;
  assign acOut     = bus.ACread ? ac_q[acIdx] : 8'h00;
  assign aluB      = bus.ALUBinputSel ? wordReg_q : di_q;
  assign aluSum    = {1'b0, dataReg_q} + {1'b0, aluB};

  assign bus.upcode   = ir1_q[7:4];
  assign bus.memAddr  = bus.memAddressSel ? addrField : pc_q;
  assign bus.memWData = dataReg_q;
  assign bus.memRd    = bus.memRead;
  assign bus.memWr    = bus.memWrite;
  assign bus.C        = c_q;
  assign bus.Z        = z_q;
  assign bus.N        = n_q;

  always_comb begin
    acWrData = 8'h00;
    case (bus.ACdataSel)
      2'b00:   acWrData = resultReg_q;
      2'b01:   acWrData = di_q;
      2'b10:   acWrData = wordReg_q;
      default: acWrData = 8'h00;
    endcase
  end

  // SUB carry is the unsigned borrow; shifts carry out the bit shifted off.
  always_comb begin
    aluResult = 8'h00;
    aluCarry  = 1'b0;
    case (bus.ALUcommand)
      3'b000: begin aluResult = aluSum[7:0];        aluCarry = aluSum[8];       end
      3'b001: begin aluResult = dataReg_q - aluB;   aluCarry = dataReg_q < aluB; end
      3'b010: aluResult = dataReg_q & aluB;
      3'b011: aluResult = dataReg_q | aluB;
      3'b100: aluResult = ~dataReg_q;
      3'b101: aluResult = aluB;
      3'b110: begin aluResult = {dataReg_q[6:0], 1'b0}; aluCarry = dataReg_q[7]; end
      default: begin aluResult = {1'b0, dataReg_q[7:1]}; aluCarry = dataReg_q[0]; end
    endcase
  end

  // All sources are current-cycle register values, so same-edge reads see old data.
  always_comb begin
    pc_d        = pc_q;
    ir1_d       = ir1_q;
    ir2_d       = ir2_q;
    di_d        = di_q;
    dataReg_d   = dataReg_q;
    wordReg_d   = wordReg_q;
    resultReg_d = resultReg_q;
    c_d         = c_q;
    z_d         = z_q;
    n_d         = n_q;
    for (int i = 0; i < 4; i++) ac_d[i] = ac_q[i];

    if (bus.pcWrite)      pc_d        = bus.pcDataSel ? addrField : pc_q + 12'd1;
    if (bus.IRwritePart1) ir1_d       = bus.memRData;
    if (bus.IRwritePart2) ir2_d       = bus.memRData;
    if (bus.DIwrite)      di_d        = bus.memRData;
    if (bus.dataRegEn)    dataReg_d   = acOut;
    if (bus.wordRegEn)    wordReg_d   = acOut;
    if (bus.resultRegEn)  resultReg_d = aluResult;
    if (bus.CEn)          c_d         = aluCarry;
    if (bus.ZEn)          z_d         = (aluResult == 8'h00);
    if (bus.NEn)          n_d         = aluResult[7];
    if (bus.ACwrite)      ac_d[acIdx] = acWrData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= 12'h000;
      ir1_q       <= 8'h00;
      ir2_q       <= 8'h00;
      di_q        <= 8'h00;
      dataReg_q   <= 8'h00;
      wordReg_q   <= 8'h00;
      resultReg_q <= 8'h00;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      for (int i = 0; i < 4; i++) ac_q[i] <= 8'h00;
    end else begin
      pc_q        <= pc_d;
      ir1_q       <= ir1_d;
      ir2_q       <= ir2_d;
      di_q        <= di_d;
      dataReg_q   <= dataReg_d;
      wordReg_q   <= wordReg_d;
      resultReg_q <= resultReg_d;
      c_q         <= c_d;
      z_q         <= z_d;
      n_q         <= n_d;
      for (int i = 0; i < 4; i++) ac_q[i] <= ac_d[i];
    end
  end
endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for the accumulator datapath; internal state is observed
// through memAddr, memWData (dataReg) and the flag outputs.
module tb_datapath;
  logic clk;
  logic rst;
  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;

  logic [7:0] expRes [8] = '{8'hFF, 8'h8B, 8'h00, 8'hFF, 8'h3A, 8'h3A, 8'h8A, 8'h62};
  logic [2:0] expCzn [8] = '{3'b001, 3'b001, 3'b010, 3'b001, 3'b000, 3'b000, 3'b101, 3'b100};

  datapath_if bus ();

  datapath dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearControls();
    bus.pcWrite = 0; bus.pcDataSel = 0; bus.memAddressSel = 0; bus.memRead = 0;
    bus.memWrite = 0; bus.ACwrite = 0; bus.ACread = 0; bus.ACaddressSel = 0;
    bus.ACdataSel = 2'b00; bus.ALUcommand = 3'b000; bus.IRwritePart1 = 0;
    bus.IRwritePart2 = 0; bus.ALUBinputSel = 0; bus.DIwrite = 0;
    bus.resultRegEn = 0; bus.dataRegEn = 0; bus.wordRegEn = 0;
    bus.CEn = 0; bus.ZEn = 0; bus.NEn = 0; bus.memRData = 8'h00;
  endtask

  // One rising edge with the currently driven controls, then back to idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearControls();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] observed,
                             input logic [11:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAddr(input string tag, input logic sel, input logic [11:0] expected);
    bus.memAddressSel = sel;
    #1;
    checkOutput(tag, bus.memAddr, expected);
    bus.memAddressSel = 0;
  endtask

  task automatic checkFlags(input string tag, input logic c, input logic z, input logic n);
    checkOutput({tag, ".C"}, {11'd0, bus.C}, {11'd0, c});
    checkOutput({tag, ".Z"}, {11'd0, bus.Z}, {11'd0, z});
    checkOutput({tag, ".N"}, {11'd0, bus.N}, {11'd0, n});
  endtask

  task automatic setIR1(input logic [7:0] v);
    bus.memRData = v; bus.IRwritePart1 = 1; applyStimulus();
  endtask

  task automatic setIR2(input logic [7:0] v);
    bus.memRData = v; bus.IRwritePart2 = 1; applyStimulus();
  endtask

  task automatic loadDI(input logic [7:0] v);
    bus.memRData = v; bus.DIwrite = 1; applyStimulus();
  endtask

  task automatic writeDstFromDI();
    bus.ACwrite = 1; bus.ACdataSel = 2'b01; applyStimulus();
  endtask

  task automatic readDstToData();
    bus.ACread = 1; bus.dataRegEn = 1; applyStimulus();
  endtask

  initial begin
    rst = 1'b1;
    clearControls();
    bus.memRead = 1;
    #1;
    checkOutput("rstMemRdFollows", {11'd0, bus.memRd}, 12'h001);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clearControls();
    #1;

    $display("[TB] reset state");
    checkOutput("rstUpcode", {8'd0, bus.upcode}, 12'h000);
    checkAddr("rstPc", 0, 12'h000);
    checkAddr("rstAddrField", 1, 12'h000);
    checkOutput("rstMemWData", {4'd0, bus.memWData}, 12'h000);
    checkFlags("rstFlags", 0, 0, 0);
    checkOutput("memRdIdle", {11'd0, bus.memRd}, 12'h000);
    bus.memWrite = 1;
    #1;
    checkOutput("memWrFollows", {11'd0, bus.memWr}, 12'h001);
    bus.memWrite = 0;

    $display("[TB] fetch and PC");
    setIR1(8'hB5);
    setIR2(8'h3C);
    checkOutput("fetchUpcode", {8'd0, bus.upcode}, 12'h00B);
    checkAddr("fetchAddrField", 1, 12'h53C);
    checkAddr("pcHoldsNoWrite", 0, 12'h000);
    bus.pcWrite = 1; applyStimulus();
    bus.pcWrite = 1; applyStimulus();
    checkAddr("pcInc2", 0, 12'h002);
    bus.pcWrite = 1; bus.pcDataSel = 1; applyStimulus();
    checkAddr("pcJump", 0, 12'h53C);
    setIR1(8'h0F);
    setIR2(8'hFF);
    bus.pcWrite = 1; bus.pcDataSel = 1; applyStimulus();
    checkAddr("pcJumpFFF", 0, 12'hFFF);
    bus.pcWrite = 1; applyStimulus();
    checkAddr("pcWrap", 0, 12'h000);

    $display("[TB] ALU directed");
    setIR1(8'h00);
    loadDI(8'hF0);
    writeDstFromDI();
    bus.ACread = 1; bus.dataRegEn = 1; bus.wordRegEn = 1; applyStimulus();
    checkOutput("dataRegF0", {4'd0, bus.memWData}, 12'h0F0);
    loadDI(8'h20);
    bus.ALUcommand = 3'b000; bus.resultRegEn = 1; bus.CEn = 1; bus.ZEn = 1; bus.NEn = 1;
    applyStimulus();
    checkFlags("addF0p20", 1, 0, 0);
    setIR1(8'h04);
    bus.ALUcommand = 3'b001; bus.ALUBinputSel = 1; bus.resultRegEn = 1;
    bus.CEn = 1; bus.ZEn = 1; bus.NEn = 1;
    bus.ACwrite = 1; bus.ACdataSel = 2'b00;
    applyStimulus();
    checkFlags("subF0mF0", 0, 1, 0);
    readDstToData();
    checkOutput("oldResultToAc", {4'd0, bus.memWData}, 12'h010);

    setIR1(8'h00);
    loadDI(8'h01);
    writeDstFromDI();
    readDstToData();
    bus.ALUcommand = 3'b111; bus.resultRegEn = 1; bus.CEn = 1; bus.ZEn = 1; bus.NEn = 1;
    applyStimulus();
    checkFlags("shr01", 1, 1, 0);

    loadDI(8'h7F);
    bus.ALUcommand = 3'b000; bus.NEn = 1;
    applyStimulus();
    checkFlags("onlyNEn", 1, 1, 1);

    $display("[TB] AC read during write");
    setIR1(8'h08);
    loadDI(8'h11);
    writeDstFromDI();
    loadDI(8'h22);
    bus.ACwrite = 1; bus.ACdataSel = 2'b01; bus.ACread = 1; bus.dataRegEn = 1;
    applyStimulus();
    checkOutput("rdwOldValue", {4'd0, bus.memWData}, 12'h011);
    readDstToData();
    checkOutput("rdwNewValue", {4'd0, bus.memWData}, 12'h022);

    $display("[TB] ALU command sweep A=C5 B=3A");
    setIR1(8'h00);
    loadDI(8'hC5);
    writeDstFromDI();
    setIR1(8'h04);
    loadDI(8'h3A);
    bus.ACread = 1; bus.ACaddressSel = 1; bus.dataRegEn = 1; applyStimulus();
    for (int i = 0; i < 8; i++) begin
      bus.ALUcommand = 3'(i); bus.resultRegEn = 1; bus.CEn = 1; bus.ZEn = 1; bus.NEn = 1;
      applyStimulus();
      checkFlags($sformatf("aluCmd%0d", i), expCzn[i][2], expCzn[i][1], expCzn[i][0]);
      bus.ACwrite = 1; bus.ACdataSel = 2'b00; applyStimulus();
      readDstToData();
      checkOutput($sformatf("aluCmd%0d.res", i), {4'd0, bus.memWData}, {4'd0, expRes[i]});
      bus.ACread = 1; bus.ACaddressSel = 1; bus.dataRegEn = 1; applyStimulus();
    end

    $display("[TB] reset mid-operation");
    setIR1(8'hA7);
    setIR2(8'h5E);
    bus.pcWrite = 1; bus.pcDataSel = 1; applyStimulus();
    checkAddr("preRstPc", 0, 12'h75E);
    loadDI(8'h66);
    bus.ACread = 1; bus.dataRegEn = 1; bus.wordRegEn = 1; applyStimulus();
    bus.ALUcommand = 3'b000; bus.resultRegEn = 1; bus.CEn = 1; bus.ZEn = 1; bus.NEn = 1;
    bus.ACwrite = 1; bus.ACaddressSel = 1; bus.ACdataSel = 2'b01;
    applyStimulus();
    checkFlags("preRstAdd", 0, 0, 1);
    checkOutput("preRstData", {4'd0, bus.memWData}, 12'h062);

    rst = 1'b1;
    bus.ACwrite = 1; bus.ACdataSel = 2'b01; bus.pcWrite = 1; bus.pcDataSel = 0;
    bus.IRwritePart1 = 1; bus.IRwritePart2 = 1; bus.DIwrite = 1; bus.memRData = 8'hFF;
    bus.ACread = 1; bus.dataRegEn = 1; bus.wordRegEn = 1; bus.resultRegEn = 1;
    bus.ALUcommand = 3'b100; bus.CEn = 1; bus.ZEn = 1; bus.NEn = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearControls();
    #1;
    checkOutput("midRstUpcode", {8'd0, bus.upcode}, 12'h000);
    checkAddr("midRstPc", 0, 12'h000);
    checkAddr("midRstAddrField", 1, 12'h000);
    checkOutput("midRstData", {4'd0, bus.memWData}, 12'h000);
    checkFlags("midRstFlags", 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      setIR1({4'h0, 2'(i), 2'b00});
      readDstToData();
      checkOutput($sformatf("midRstAc%0d", i), {4'd0, bus.memWData}, 12'h000);
    end
    bus.ALUcommand = 3'b101; bus.ZEn = 1; applyStimulus();
    checkOutput("midRstDIZero", {11'd0, bus.Z}, 12'h001);
    bus.ALUcommand = 3'b100; bus.ZEn = 1; applyStimulus();
    checkOutput("notZeroClearsZ", {11'd0, bus.Z}, 12'h000);
    bus.ALUcommand = 3'b101; bus.ALUBinputSel = 1; bus.ZEn = 1; applyStimulus();
    checkOutput("midRstWordZero", {11'd0, bus.Z}, 12'h001);
    loadDI(8'h55);
    writeDstFromDI();
    bus.ACwrite = 1; bus.ACdataSel = 2'b00; applyStimulus();
    readDstToData();
    checkOutput("midRstResultZero", {4'd0, bus.memWData}, 12'h000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have these control inputs, each 1 bit unless stated: pcWrite, pcDataSel, memAddressSel, memRead, memWrite, ACwrite, ACread, ACdataSel (2 bits), ALUcommand (3 bits), IRwritePart1, IRwritePart2, ALUBinputSel, DIwrite, ACaddressSel, resultRegEn, dataRegEn, wordRegEn, CEn, ZEn, NEn.
REQ-004 SHALL have port upcode, output, 4: IR1[7:4], returned to the controller.
REQ-005 SHALL have ports C, Z, N, outputs, 1 each: registered flags.
REQ-006 SHALL have port memAddr, output, 12: memory address.
REQ-007 SHALL have port memWData, output, 8: always equal to dataReg.
REQ-008 SHALL have port memRData, input, 8: memory read data, valid in the same cycle as memRead.
REQ-009 SHALL have ports memRd and memWr, outputs, 1 each: combinational copies of memRead and memWrite.

Function
REQ-010 SHALL hold state PC (12 bits), IR1 and IR2 (8 bits each), DI, dataReg, wordReg and resultReg (8 bits each), AC[0..3] (8 bits each), and flags C, Z and N.
REQ-011 SHALL define addrField = {IR1[3:0], IR2}, dstIdx = IR1[3:2], srcIdx = IR1[1:0].
REQ-012 SHALL drive memAddr = PC when memAddressSel=0, and addrField when memAddressSel=1.
REQ-013 SHALL, on pcWrite, load PC with (PC+1) mod 4096 when pcDataSel=0, and with addrField when pcDataSel=1.
REQ-014 SHALL load IR1 from memRData on IRwritePart1 and IR2 from memRData on IRwritePart2; both may assert in the same cycle and both then load.
REQ-015 SHALL load DI from memRData on DIwrite.
REQ-016 SHALL select the AC index acIdx = dstIdx when ACaddressSel=0, and srcIdx when ACaddressSel=1.
REQ-017 SHALL produce acOut = AC[acIdx] when ACread=1, and 8'h00 otherwise; the read is combinational.
REQ-018 SHALL load dataReg from acOut on dataRegEn and wordReg from acOut on wordRegEn.
REQ-019 SHALL, on ACwrite, write AC[acIdx] from the ACdataSel source: 00 resultReg, 01 DI, 10 wordReg, 11 8'h00.
REQ-020 SHALL return the old value on a same-cycle AC read of the index being written; there is no write-through.
REQ-021 SHALL use ALU operand A = dataReg, and operand B = DI when ALUBinputSel=0, wordReg when ALUBinputSel=1.
REQ-022 SHALL implement ALUcommand: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 ~A, 101 B, 110 A<<1, 111 A>>1 (logical); the result is 8 bits.
REQ-023 SHALL compute the carry as: ADD carry-out of the 9-bit sum; SUB 1 iff A<B unsigned (borrow); SHL A[7]; SHR A[0]; all other commands 0.
REQ-024 SHALL compute zero = (result==0) and neg = result[7].
REQ-025 SHALL load resultReg from the ALU result on resultRegEn; C, Z and N SHALL each load independently on CEn, ZEn and NEn from the current-cycle ALU outputs.
REQ-026 SHALL apply every register update exactly one edge after its enable is sampled high; unenabled registers hold.
REQ-027 SHALL, with simultaneous resultRegEn and ACwrite selecting resultReg, write the old resultReg into the AC.

Reset
REQ-028 SHALL, with rst=1 at an edge, clear PC, IR1, IR2, DI, dataReg, wordReg, resultReg, all AC entries and C, Z, N to 0; rst overrides every enable.
REQ-029 SHALL, after reset, present upcode=0000, memAddr=000, memWData=00 and C=Z=N=0; memRd and memWr follow their inputs even during reset.
REQ-030 SHALL abandon any operation when reset is asserted mid-instruction; no partial write survives the reset edge.

Verification
REQ-031 SHALL cover fetch: memRData=8'hB5 with IRwritePart1, then 8'h3C with IRwritePart2 -> upcode=1011, addrField=0x53C; pcWrite with pcDataSel=0 twice -> PC=002.
REQ-032 SHALL cover PC wrap: PC=FFF, pcWrite with pcDataSel=0 -> PC=000; jump with pcDataSel=1 -> PC=addrField.
REQ-033 SHALL cover the ALU: dataReg=F0, DI=20, ADD -> resultReg=10, C=1, Z=0, N=0; SUB with B=F0 -> 00, C=0, Z=1; SHR of 01 -> 00, C=1, Z=1.
REQ-034 SHALL cover AC read-during-write: AC[2]=11, ACwrite index 2 with DI=22 and dataRegEn in the same cycle -> dataReg=11, AC[2]=22 afterwards.
REQ-035 SHALL cover selective flags: ADD producing 80 with only NEn=1 -> N=1, C and Z unchanged.
REQ-036 SHALL cover mid-operation reset: load all registers non-zero, assert rst together with ACwrite and pcWrite -> all state 0 on the next cycle.
